prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 4: instruction memory address width; depth DEPTH = 2^ADDR_W.
REQ-002 Parameter DATA_W, default 8: instruction width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream byte valid.
REQ-006 in_data  input  DATA_W  upstream byte.
REQ-007 in_ready  output  1  loader accepts byte; transfer occurs when in_valid && in_ready at clk edge.
REQ-008 load_req  input  1  one-cycle request to (re)start a load.
REQ-009 mem_we  output  1  instruction memory write strobe.
REQ-010 mem_addr  output  ADDR_W  instruction memory write address.
REQ-011 mem_wdata  output  DATA_W  instruction memory write data.
REQ-012 cpu_run  output  1  high releases the CPU to fetch; low holds it stalled.
REQ-013 error  output  1  load failed; sticky until load_req.

Function
REQ-014 States: WAIT_LEN, LOAD, CHECK, RUN, ERR; encoding is free.
REQ-015 WAIT_LEN: in_ready=1; accepted byte is length L (unsigned); 1 <= L <= DEPTH -> LOAD, count=0, checksum=0; L=0 or L>DEPTH -> ERR.
REQ-016 LOAD: in_ready=1; each accepted byte b -> next cycle mem_we=1, mem_addr=count, mem_wdata=b (1-cycle registered latency); count+1; checksum ^= b.
REQ-017 mem_we is high for exactly one cycle per accepted LOAD byte and low in every other cycle.
REQ-018 After the L-th LOAD byte: -> CHECK (macro defined) or RUN (macro undefined).
REQ-019 CHECK: in_ready=1; accepted byte == checksum -> RUN; mismatch -> ERR; no memory write.
REQ-020 RUN: cpu_run=1, in_ready=0; in_valid ignored.
REQ-021 ERR: error=1, cpu_run=0, in_ready=0; in_valid ignored.
REQ-022 cpu_run=1 only in RUN; error=1 only in ERR; both registered outputs.
REQ-023 load_req in any state -> WAIT_LEN next cycle; cpu_run and error clear that same edge; count and checksum clear.
REQ-024 load_req with simultaneous accepted byte: load_req wins; byte discarded; a pending mem_we from the previous cycle's acceptance still issues.
REQ-025 load_req mid-LOAD: partial load abandoned; already-written locations retain contents; no cleanup writes.
REQ-026 count never exceeds L; no address wrap inside a load; L=DEPTH writes addresses 0..DEPTH-1 exactly once.
REQ-027 in_valid held with in_ready=0: no state change, no write.

Reset
REQ-028 rst_n low: state=WAIT_LEN, count=0, checksum=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, error=0; in_ready=1 from first cycle after release.
REQ-029 Reset asserted mid-LOAD or mid-RUN aborts immediately; a pending write is dropped.

Configuration
REQ-030 Macro PROG_LOADER_CHECKSUM_EN defined: CHECK state and XOR checksum implemented per REQ-019.
REQ-031 Macro undefined: no CHECK state or checksum register; LOAD -> RUN after the L-th byte; only REQ-015 length errors reach ERR.

Verification
REQ-032 Reset, send L=4, bytes 08,19,2A,3B, checksum 00 -> writes (0,08),(1,19),(2,2A),(3,3B), each 1 cycle after acceptance; cpu_run=1; error=0.
REQ-033 L=2, bytes 08,19, checksum 00 (expected 11) -> ERR, error=1, cpu_run=0; load_req -> error=0, in_ready=1.
REQ-034 L=0 and separately L=17 (ADDR_W=4) -> ERR, no mem_we.
REQ-035 L=16, bytes 00..0F, in_valid toggled randomly -> 16 writes to addresses 0..15 in order, checksum 00 -> RUN.
REQ-036 L=4, load_req after 2 bytes concurrent with 3rd byte -> exactly 2 writes, state WAIT_LEN, 3rd byte not written.
REQ-037 rst_n low one cycle after 2nd LOAD byte -> that byte's mem_we absent; all outputs at REQ-028 values.

Source files
------------

// File: rtl/prog_loader.sv
// Streams a length-prefixed program into instruction memory, then releases the CPU.
// Optional XOR checksum trailer byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              load_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic              error
);

  localparam int unsigned        DEPTH   = 2 ** ADDR_W;
  localparam logic [DATA_W:0]    MAX_LEN = (DATA_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]    ONE     = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_WAIT_LEN,
    S_LOAD,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_RUN,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   count_inc;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              run_q, run_d;
  logic              err_q, err_d;
  logic              accept;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  assign count_inc = count_q + ONE;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    in_ready = (state_q == S_WAIT_LEN) || (state_q == S_LOAD) || (state_q == S_CHECK);
`else
    in_ready = (state_q == S_WAIT_LEN) || (state_q == S_LOAD);
`endif

    // load_req overrides everything, including a byte accepted on the same edge
    if (load_req) begin
      state_d = S_WAIT_LEN;
      count_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else begin
      case (state_q)
        S_WAIT_LEN: begin
          if (accept) begin
            if ((in_data == '0) || ({1'b0, in_data} > MAX_LEN)) begin
              state_d = S_ERR;
            end else begin
              state_d = S_LOAD;
              len_d   = in_data[ADDR_W:0];
              count_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
              csum_d  = '0;
`endif
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_W-1:0];
            wdata_d = in_data;
            count_d = count_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_d  = csum_q ^ in_data;
            if (count_inc == len_q) state_d = S_CHECK;
`else
            if (count_inc == len_q) state_d = S_RUN;
`endif
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (accept) state_d = (in_data == csum_q) ? S_RUN : S_ERR;
        end
`endif
        default: ;
      endcase
    end

    run_d = (state_d == S_RUN);
    err_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT_LEN;
      len_q   <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      run_q   <= run_d;
      err_q   <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_run   = run_q;
  assign error     = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: scoreboard of expected memory writes plus status checks.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       load_req;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_run;
  logic       error;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int unsigned cyc    = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [7:0]  data;
    int unsigned when;
  } wr_t;
  wr_t wq[$];

  prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .load_req(load_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_run(cpu_run), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wdata, e.data);
        chk("wr_cycle", cyc, e.when);
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit wr, input logic [3:0] a);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      if (in_ready) begin
        @(posedge clk);
        #1;
        if (wr) wq.push_back('{addr: a, data: b, when: cyc});
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("send_timeout", 1, 0);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic pulse_load_req();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    chk("lr_cpu_run", cpu_run, 0);
    chk("lr_error", error, 0);
    chk("lr_in_ready", in_ready, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_cpu_run"}, cpu_run, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; load_req = 1'b0;
    idle(3);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    idle(1);
    chk("rst_in_ready", in_ready, 1);

    // Basic load of four bytes
    send(8'd4, 0, 0);
    send(8'h08, 1, 0); send(8'h19, 1, 1); send(8'h2A, 1, 2); send(8'h3B, 1, 3);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h00, 0, 0);
`endif
    idle(2);
    chk("run_cpu_run", cpu_run, 1);
    chk("run_error", error, 0);
    chk("run_in_ready", in_ready, 0);
    // in_valid held while not ready: nothing changes, no writes
    @(negedge clk); in_valid = 1'b1; in_data = 8'hEE;
    idle(0); @(negedge clk); @(negedge clk); in_valid = 1'b0;
    chk("run_hold_cpu_run", cpu_run, 1);
    chk("q_empty_a", wq.size(), 0);
    pulse_load_req();

    // Short load with wrong checksum
    send(8'd2, 0, 0);
    send(8'h08, 1, 0); send(8'h19, 1, 1);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h00, 0, 0);
    idle(1);
    chk("bad_csum_error", error, 1);
    chk("bad_csum_cpu_run", cpu_run, 0);
    chk("bad_csum_in_ready", in_ready, 0);
`else
    idle(1);
    chk("short_cpu_run", cpu_run, 1);
    chk("short_error", error, 0);
`endif
    pulse_load_req();

    // Illegal lengths
    send(8'd0, 0, 0);
    idle(1);
    chk("len0_error", error, 1);
    chk("len0_cpu_run", cpu_run, 0);
    pulse_load_req();
    send(8'd17, 0, 0);
    idle(1);
    chk("len17_error", error, 1);
    chk("len17_in_ready", in_ready, 0);
    pulse_load_req();

    // Full-depth load with random gaps
    send(8'd16, 0, 0);
    for (int i = 0; i < 16; i++) begin
      idle($urandom_range(0, 2));
      send(8'(i), 1, 4'(i));
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h00, 0, 0);
`endif
    idle(2);
    chk("full_cpu_run", cpu_run, 1);
    chk("full_error", error, 0);
    chk("q_empty_b", wq.size(), 0);
    pulse_load_req();

    // load_req concurrent with the third byte: byte dropped, pending write issues
    send(8'd4, 0, 0);
    send(8'h08, 1, 0); send(8'h19, 1, 1);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h2A; load_req = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; load_req = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_cpu_run", cpu_run, 0);
    chk("abort_mem_we", mem_we, 0);
    // A fresh load must start at address 0
    send(8'd1, 0, 0);
    send(8'h55, 1, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h55, 0, 0);
`endif
    idle(2);
    chk("fresh_cpu_run", cpu_run, 1);
    chk("q_empty_c", wq.size(), 0);
    pulse_load_req();

    // Reset right after the second byte drops its write
    send(8'd4, 0, 0);
    send(8'h08, 1, 0);
    send(8'h19, 0, 0);
    rst_n = 1'b0;
    idle(2);
    chk_reset_vals("midrst");
    rst_n = 1'b1;
    idle(1);
    chk("midrst_in_ready", in_ready, 1);
    send(8'd1, 0, 0);
    send(8'h77, 1, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h77, 0, 0);
`endif
    idle(2);
    chk("post_rst_cpu_run", cpu_run, 1);
    chk("q_empty_end", wq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
